// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the byte-stream program loader.
// The optional inter-byte timeout is enabled with PROG_LOADER_TIMEOUT_EN.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        COUNT,
        DATA,
        CSUM,
        DONE,
        ERR
    } loader_state_t;

    localparam logic [7:0] SYNC_BYTE      = 8'hA5;
    localparam int         BYTES_PER_WORD = 4;

endpackage

// File: rtl/prog_loader.sv
// Loads framed instruction words (A5, N, N x 4 bytes, XOR checksum) into program memory.
// Define PROG_LOADER_TIMEOUT_EN to abort a stalled frame after TO_CYCLES idle cycles.
//
// state | meaning
// IDLE  | after reset, CPU held, waiting for start
// SYNC  | waiting for the 0xA5 sync byte
// COUNT | waiting for the word count byte
// DATA  | assembling words, one write per 4 bytes
// CSUM  | comparing the checksum byte with the running XOR
// DONE  | load good, CPU released
// ERR   | load failed, CPU held
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int p         = 6,
    parameter int i         = 24,
    parameter int TO_CYCLES = 100000
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic         wr_en,
    output logic [p-1:0] wr_addr,
    output logic [i:0]   wr_data,
    output logic         cpu_hold,
    output logic         done,
    output logic         err
);

    localparam int         W         = i + 1;
    localparam int         DEPTH     = 2 ** p;
    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    loader_state_t state, state_next;

    logic [23:0]  word_reg;
    logic [1:0]   byte_idx;
    logic [7:0]   csum;
    logic [7:0]   words_left;
    logic [W-1:0] word_full;
    logic         active;
    logic         take_data;
    logic         word_last_byte;
    logic         count_bad;
    logic         timeout;

    assign active         = (state == SYNC) || (state == COUNT) || (state == DATA) || (state == CSUM);
    assign take_data      = (state == DATA) && rx_valid;
    assign word_last_byte = take_data && (byte_idx == LAST_BYTE);
    assign count_bad      = (rx_data == 8'd0) || ({24'd0, rx_data} > 32'(DEPTH));
    // Upper bits of the 32-bit assembly beyond the instruction width are dropped here.
    assign word_full      = W'({word_reg, rx_data});

`ifdef PROG_LOADER_TIMEOUT_EN
    localparam int TO_W = $clog2(TO_CYCLES + 1);

    logic [TO_W-1:0] to_cnt;

    // Reloaded while not loading, so entry to SYNC always starts a full interval.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            to_cnt <= TO_W'(TO_CYCLES);
        end else if (rx_valid || !active) begin
            to_cnt <= TO_W'(TO_CYCLES);
        end else if (to_cnt != '0) begin
            to_cnt <= to_cnt - 1'b1;
        end
    end

    assign timeout = active && !rx_valid && (to_cnt == TO_W'(1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        done       = 1'b0;
        err        = 1'b0;
        cpu_hold   = 1'b1;
        case (state)
            IDLE: begin
                if (start) state_next = SYNC;
            end
            SYNC: begin
                if (rx_valid) state_next = (rx_data == SYNC_BYTE) ? COUNT : ERR;
            end
            COUNT: begin
                if (rx_valid) state_next = count_bad ? ERR : DATA;
            end
            DATA: begin
                if (word_last_byte && (words_left == 8'd1)) state_next = CSUM;
            end
            CSUM: begin
                if (rx_valid) state_next = (rx_data == csum) ? DONE : ERR;
            end
            DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
                if (start) state_next = SYNC;
            end
            ERR: begin
                err = 1'b1;
                if (start) state_next = SYNC;
            end
            default: state_next = IDLE;
        endcase
        if (timeout) state_next = ERR;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            word_reg   <= '0;
            byte_idx   <= '0;
            csum       <= '0;
            words_left <= '0;
        end else begin
            wr_en <= word_last_byte;
            if (wr_en) begin
                wr_addr <= wr_addr + 1'b1;
            end
            if ((state == COUNT) && rx_valid && !count_bad) begin
                words_left <= rx_data;
                wr_addr    <= '0;
                byte_idx   <= '0;
                csum       <= '0;
                word_reg   <= '0;
            end
            if (take_data) begin
                word_reg <= {word_reg[15:0], rx_data};
                csum     <= csum ^ rx_data;
                byte_idx <= byte_idx + 1'b1;
                if (byte_idx == LAST_BYTE) begin
                    wr_data    <= word_full;
                    words_left <= words_left - 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed testbench for prog_loader with a frame-level model and a per-cycle write checker.
module tb_prog_loader;
    import prog_loader_pkg::*;

    localparam int P  = 6;
    localparam int I  = 24;
    localparam int W  = I + 1;
    localparam int TO = 50;

    logic         clock    = 1'b0;
    logic         reset    = 1'b1;
    logic         start    = 1'b0;
    logic [7:0]   rx_data  = 8'h00;
    logic         rx_valid = 1'b0;
    logic         wr_en;
    logic [P-1:0] wr_addr;
    logic [I:0]   wr_data;
    logic         cpu_hold;
    logic         done;
    logic         err;

    typedef struct {
        logic [P-1:0] addr;
        logic [W-1:0] data;
    } wr_t;

    int           total = 0;
    int           bad   = 0;
    wr_t          exp_q[$];
    wr_t          exp_e;
    logic [W-1:0] seen[$];
    logic [7:0]   frame[$];
    logic [31:0]  wq[$];
    logic         exp_done;
    logic         exp_err;
    int           exp_addr;

    always #5 clock = ~clock;

    prog_loader #(.p(P), .i(I), .TO_CYCLES(TO)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Every write the DUT makes must be the next one the model predicted.
    always @(negedge clock) begin
        if (!reset) begin
            if (wr_en) begin
                seen.push_back(wr_data);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write", wr_addr, wr_data);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("wr_addr", 32'(wr_addr), 32'(exp_e.addr));
                    check("wr_data", 32'(wr_data), 32'(exp_e.data));
                end
            end
            check("hold_is_not_done", 32'(cpu_hold), 32'(!done));
            check("done_err_exclusive", 32'(done & err), 32'd0);
        end
    end

    // Frame model: decides outcome and the write list purely from the byte sequence.
    task automatic predict();
        int          n;
        logic [7:0]  x;
        logic [31:0] w;
        exp_done = 1'b0;
        exp_err  = 1'b1;
        exp_addr = -1;
        if (frame.size() < 2 || frame[0] != 8'hA5) return;
        n = int'(frame[1]);
        if (n == 0 || n > 64) return;
        x = 8'h00;
        for (int k = 0; k < n; k++) begin
            w = {frame[2+4*k], frame[3+4*k], frame[4+4*k], frame[5+4*k]};
            x = x ^ frame[2+4*k] ^ frame[3+4*k] ^ frame[4+4*k] ^ frame[5+4*k];
            exp_q.push_back('{P'(k), W'(w)});
        end
        exp_done = (frame[2+4*n] == x);
        exp_err  = !exp_done;
        exp_addr = n % 64;
    endtask

    task automatic build_frame(input logic [7:0] flip);
        logic [7:0] x;
        x = 8'h00;
        frame = {};
        frame.push_back(8'hA5);
        frame.push_back(8'(wq.size()));
        foreach (wq[k]) begin
            for (int b = 3; b >= 0; b--) begin
                frame.push_back(wq[k][8*b +: 8]);
                x = x ^ wq[k][8*b +: 8];
            end
        end
        frame.push_back(x ^ flip);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clock);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic run_frame(input string name, input bit do_start, input int gap);
        predict();
        seen = {};
        if (do_start) pulse_start();
        foreach (frame[k]) begin
            send_byte(frame[k]);
            if (k != frame.size() - 1) repeat (gap) @(posedge clock);
            if (k != frame.size() - 1 && gap > 0) #1;
        end
        @(negedge clock);
        check({name, "_done"}, 32'(done), 32'(exp_done));
        check({name, "_err"}, 32'(err), 32'(exp_err));
        check({name, "_hold"}, 32'(cpu_hold), 32'(!exp_done));
        check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
        if (exp_addr >= 0) check({name, "_end_addr"}, 32'(wr_addr), 32'(exp_addr));
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_wr_en"}, 32'(wr_en), 32'd0);
        check({name, "_wr_addr"}, 32'(wr_addr), 32'd0);
        check({name, "_wr_data"}, 32'(wr_data), 32'd0);
        check({name, "_hold"}, 32'(cpu_hold), 32'd1);
        check({name, "_done"}, 32'(done), 32'd0);
        check({name, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check_reset_values("reset");
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("idle_hold", 32'(cpu_hold), 32'd1);

        wq = {32'h00123456, 32'h01ABCDEF, 32'h00000001};
        build_frame(8'h00);
        check("model_csum_3w", 32'(frame[frame.size()-1]), 32'hF9);
        run_frame("good3", 1'b1, 0);
        check("good3_count", 32'(seen.size()), 32'd3);
        if (seen.size() == 3) begin
            check("lit_w0", 32'(seen[0]), 32'h0123456);
            check("lit_w1", 32'(seen[1]), 32'h1ABCDEF);
            check("lit_w2", 32'(seen[2]), 32'h0000001);
        end

        send_byte(8'h33);
        @(negedge clock);
        check("stray_done", 32'(done), 32'd1);
        check("stray_addr", 32'(wr_addr), 32'd3);
        @(posedge clock);
        #1;

        frame = {8'h5A};
        run_frame("bad_sync", 1'b1, 0);

        wq = {32'hFFFFFFFF};
        build_frame(8'h00);
        run_frame("after_err", 1'b1, 0);
        if (seen.size() == 1) check("lit_trunc", 32'(seen[0]), 32'h1FFFFFF);

        frame = {8'hA5, 8'h00};
        run_frame("n0", 1'b1, 0);
        frame = {8'hA5, 8'h41};
        run_frame("n65", 1'b1, 0);

        wq = {};
        for (int k = 0; k < 64; k++) wq.push_back((32'(k) * 32'h01030507) ^ 32'(k));
        build_frame(8'h00);
        run_frame("n64", 1'b1, 0);
        check("n64_count", 32'(seen.size()), 32'd64);
        check("n64_end_addr_lit", 32'(wr_addr), 32'd0);

        wq = {32'hFE000007};
        build_frame(8'h01);
        run_frame("csum_bad", 1'b1, 0);
        if (seen.size() == 1) check("lit_csum_bad_w", 32'(seen[0]), 32'h0000007);
        check("lit_csum_bad_addr", 32'(wr_addr), 32'd1);

        // start together with a byte in ERR: the byte must not count as the sync byte
        start    = 1'b1;
        rx_data  = 8'hA5;
        rx_valid = 1'b1;
        @(posedge clock);
        #1;
        start    = 1'b0;
        rx_valid = 1'b0;
        wq = {32'h00ABCDEF};
        build_frame(8'h00);
        run_frame("start_and_byte", 1'b0, 0);

        pulse_start();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h12);
        send_byte(8'h34);
        reset = 1'b1;
        #1;
        check_reset_values("mid_reset");
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        wq = {32'h00000055, 32'h00AA0000};
        build_frame(8'h00);
        run_frame("post_reset", 1'b1, 0);

`ifdef PROG_LOADER_TIMEOUT_EN
        pulse_start();
        send_byte(8'hA5);
        send_byte(8'h02);
        repeat (49) @(posedge clock);
        #1;
        check("to_49_no_err", 32'(err), 32'd0);
        @(posedge clock);
        #1;
        check("to_50_err", 32'(err), 32'd1);
        check("to_50_hold", 32'(cpu_hold), 32'd1);
        wq = {32'h00010203, 32'h00040506};
        build_frame(8'h00);
        run_frame("gap49", 1'b1, 49);
`endif

        check("final_pending", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Byte-stream program loader that writes instruction words into the processor's program memory before execution. It sits between a byte receiver (e.g. UART RX) and the program memory write port. It holds the CPU in reset while loading and validates the transfer with a header, word count and XOR checksum. It is the write-side counterpart of the combinational program-memory read path.

## Interface
- `p`, 6, program address width; memory depth is 2^p words.
- `i`, 24, instruction MSB index; instruction word is i+1 bits (25 by default).
- `TO_CYCLES`, 100000, inter-byte timeout in clock cycles; only used when the timeout feature is compiled in.

- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle load request.
- `rx_data`  in  8  received byte.
- `rx_valid`  in  1  single-cycle strobe; `rx_data` is valid in this cycle.
- `wr_en`  out  1  program memory write strobe, one cycle per word.
- `wr_addr`  out  p  program memory write address.
- `wr_data`  out  i+1  instruction word to write.
- `cpu_hold`  out  1  holds the CPU in reset while high.
- `done`  out  1  load completed with a good checksum (level).
- `err`  out  1  load failed (level).

## Operation
- **Frame format:**
  - Sync byte 0xA5.
  - Count byte N: number of words.
  - N words, each 4 bytes, MSB byte first. Only the low i+1 bits of the 32-bit assembly are kept; excess upper bits are discarded.
  - Checksum byte: XOR of every word byte. The sync and count bytes are excluded.
- **States:** IDLE, SYNC, COUNT, DATA, CSUM, DONE, ERR.
  - IDLE: `cpu_hold`=1. `start` → SYNC.
  - SYNC: byte 0xA5 → COUNT. Any other byte → ERR.
  - COUNT: N=0 or N>2^p → ERR. Otherwise latch N, clear the address, byte index and checksum, then → DATA.
  - DATA: shift each byte into the word register and fold it into the checksum.
    - On the 4th byte, the next cycle drives `wr_en`=1 with the current `wr_addr`, and the address increments after that write.
    - After word N is written → CSUM.
  - CSUM: byte equal to the running XOR → DONE. Otherwise → ERR.
  - DONE: `done`=1, `cpu_hold`=0. `start` → SYNC and clears `done`.
  - ERR: `err`=1, `cpu_hold`=1. `start` → SYNC and clears `err`.
- `start` is ignored in SYNC, COUNT, DATA and CSUM. A load in progress is never restarted.
- `rx_valid` while in IDLE, DONE or ERR is ignored.
- `wr_addr` never wraps within a frame, because N is limited to 2^p. After the last write it holds the value N mod 2^p.
- Words not covered by the frame are left untouched in memory.

## Timing
- **Reset values:** state IDLE, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `cpu_hold`=1, `done`=0, `err`=0, checksum 0, byte index 0.
- **Write latency:** `wr_en` pulses for exactly one cycle, in the cycle after the `rx_valid` of byte 4. `wr_data` and `wr_addr` are stable in that cycle.
- **Status latency:** `done`/`err` rise, and `cpu_hold` falls, one cycle after the `rx_valid` of the deciding byte.
- **Back-to-back bytes:** `rx_valid` on consecutive cycles is supported. A write pulse can coincide with the first byte of the next word.
- **Reset mid-frame:** state → IDLE immediately. Any partial word is dropped with no write, and `cpu_hold` is forced to 1.
- **Simultaneous `start` and `rx_valid` in DONE/ERR:** go to SYNC; the byte is ignored.

## Configuration
- `PROG_LOADER_TIMEOUT_EN` defined:
  - A counter clears on every `rx_valid` and on entry to SYNC.
  - If it reaches `TO_CYCLES` in SYNC, COUNT, DATA or CSUM → ERR. No partial word is written.
- `PROG_LOADER_TIMEOUT_EN` undefined: no counter, no timeout; the loader waits indefinitely for bytes.

## Structure
- **Package `prog_loader_pkg`:** state enum `loader_state_t`, `SYNC_BYTE` = 8'hA5, `BYTES_PER_WORD` = 4.
- Single module with no sub-module; the optional timeout counter stays inline under the macro.

## Test plan
- **Good 3-word load:** A5, 03, then bytes for 0x0123456, 0x1ABCDEF, 0x0000001, then the correct checksum → three `wr_en` pulses at addr 0, 1, 2 with those words; `done`=1, `cpu_hold`=0.
- **Bad sync:** `start`, then 0x5A → `err`=1, no `wr_en`, `cpu_hold`=1. A following `start` plus a good frame → `done`=1, `err`=0.
- **Count boundaries:** N=0 → ERR. N=65 with p=6 → ERR. N=64 with full data and checksum → 64 writes, last at addr 63, `done`=1.
- **Checksum mismatch:** good 1-word frame with checksum XOR 0x01 → word still written at addr 0, `err`=1, `done`=0.
- **Reset mid-word:** assert `reset` after 2 of 4 bytes → no `wr_en`, all outputs at reset values. A fresh `start` and frame load correctly from addr 0.
- **Timeout** (`PROG_LOADER_TIMEOUT_EN`, `TO_CYCLES`=50): stall 50 cycles after the count byte → `err`=1. With 49 cycles between bytes → `done`=1.
